hazard_forward_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage pipelined core. Drives the Sel inputs of the two EX-stage 3:1 operand muxes (A and B) and the stall/flush controls for the IF, ID and EX pipeline registers.
- Keeps its own shadow of the destination register and write flags for EX, MEM and WB, advanced every clock.
- Forward selects are registered, so they are valid while the consuming instruction is in EX.
- Stall and flush outputs are combinational from internal state plus the current ID inputs.

---
 rtl/hazard_forward_ctrl.sv | 120 ++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage core: registered EX operand-mux selects, combinational stall/flush.
// Optional macro MULDIV_STALL_EN adds a multiplier busy counter that stalls HI/LO readers.
module hazard_forward_ctrl #(
  parameter int RAW     = 5,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 16,
  parameter int MUL_LAT = 4
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             ID_Valid,
  input  logic [RAW-1:0]   ID_Rs,
  input  logic [RAW-1:0]   ID_Rt,
  input  logic [RAW-1:0]   ID_WriteReg,
  input  logic             ID_RegWrite,
  input  logic             ID_MemToReg,
  input  logic             ID_BranchTaken,
  input  logic             ID_MulStart,
  input  logic             ID_ReadHiLo,
  output logic [SEL_W-1:0] ForwardAE,
  output logic [SEL_W-1:0] ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(2);

  logic [RAW-1:0]   ex_dst_q, ex_dst_d, mem_dst_q, wb_dst_q;
  logic             ex_rw_q, ex_rw_d, ex_ld_q, ex_ld_d, mem_rw_q, wb_rw_q;
  logic [SEL_W-1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu, stall;

  assign lu = ID_Valid & ex_ld_q & ex_rw_q & (ex_dst_q != '0) &
              ((ex_dst_q == ID_Rs) | (ex_dst_q == ID_Rt));

`ifdef MULDIV_STALL_EN
  localparam int BW = $clog2(MUL_LAT + 1);
  logic [BW-1:0] busy_q, busy_d;

  assign stall = lu | ((busy_q != '0) & ID_ReadHiLo & ID_Valid);

  // A new multiply while busy restarts the full latency.
  always_comb begin
    busy_d = busy_q;
    if (ID_MulStart & ID_Valid & ~stall) busy_d = BW'(MUL_LAT);
    else if (busy_q != '0)               busy_d = busy_q - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  logic unused_sig;
  assign unused_sig = ^{wb_dst_q, wb_rw_q};
`else
  assign stall = lu;

  logic unused_sig;
  assign unused_sig = ^{wb_dst_q, wb_rw_q, ID_MulStart, ID_ReadHiLo} ^ (MUL_LAT != 0);
`endif

  assign StallF     = stall;
  assign StallD     = stall;
  assign FlushE     = stall;
  assign FlushD     = ID_BranchTaken & ID_Valid & ~stall;
  assign ForwardAE  = fwd_a_q;
  assign ForwardBE  = fwd_b_q;
  assign StallCount = cnt_q;

  // Youngest producer (about to enter MEM) wins over the older one.
  function automatic logic [SEL_W-1:0] fwd_sel(input logic [RAW-1:0] s);
    if (stall || !ID_Valid || s == '0)  return SEL_RF;
    if (ex_rw_q && ex_dst_q == s)       return SEL_MEM;
    if (mem_rw_q && mem_dst_q == s)     return SEL_WB;
    return SEL_RF;
  endfunction

  always_comb begin
    fwd_a_d  = fwd_sel(ID_Rs);
    fwd_b_d  = fwd_sel(ID_Rt);
    ex_dst_d = stall ? '0   : ID_WriteReg;
    ex_rw_d  = stall ? 1'b0 : (ID_RegWrite & ID_Valid);
    ex_ld_d  = stall ? 1'b0 : (ID_MemToReg & ID_Valid);
    cnt_d    = (stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      ex_dst_q  <= '0;
      ex_rw_q   <= 1'b0;
      ex_ld_q   <= 1'b0;
      mem_dst_q <= '0;
      mem_rw_q  <= 1'b0;
      wb_dst_q  <= '0;
      wb_rw_q   <= 1'b0;
      fwd_a_q   <= SEL_RF;
      fwd_b_q   <= SEL_RF;
      cnt_q     <= '0;
    end else begin
      wb_dst_q  <= mem_dst_q;
      wb_rw_q   <= mem_rw_q;
      mem_dst_q <= ex_dst_q;
      mem_rw_q  <= ex_rw_q;
      ex_dst_q  <= ex_dst_d;
      ex_rw_q   <= ex_rw_d;
      ex_ld_q   <= ex_ld_d;
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed scenarios plus random traffic against a pipeline-occupancy model.
module tb_hazard_forward_ctrl;
  localparam int RAW = 5, SEL_W = 2, CNT_W = 4, MUL_LAT = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic RST_n;
  logic ID_Valid, ID_RegWrite, ID_MemToReg, ID_BranchTaken, ID_MulStart, ID_ReadHiLo;
  logic [RAW-1:0] ID_Rs, ID_Rt, ID_WriteReg;
  logic [SEL_W-1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, FlushD, FlushE;
  logic [CNT_W-1:0] StallCount;

  hazard_forward_ctrl #(.RAW(RAW), .SEL_W(SEL_W), .CNT_W(CNT_W), .MUL_LAT(MUL_LAT)) dut (
    .CLK(clk), .RST_n(RST_n), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_WriteReg(ID_WriteReg), .ID_RegWrite(ID_RegWrite), .ID_MemToReg(ID_MemToReg),
    .ID_BranchTaken(ID_BranchTaken), .ID_MulStart(ID_MulStart), .ID_ReadHiLo(ID_ReadHiLo),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .StallCount(StallCount));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  // Model: which instruction occupies EX and MEM, plus cycle stamp of the last accepted multiply.
  typedef struct { bit w; int dst; bit ld; } slot_t;
  slot_t m_ex = '{0, 0, 0}, m_mem = '{0, 0, 0};
  int exp_fa = 0, exp_fb = 0, exp_cnt = 0;
  int cyc = 0, mul_t = -100;

`ifdef MULDIV_STALL_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  function automatic bit m_stall();
    bit lu, busy;
    lu = ID_Valid && m_ex.w && m_ex.ld && m_ex.dst != 0 &&
         (m_ex.dst == int'(ID_Rs) || m_ex.dst == int'(ID_Rt));
    busy = MULDIV && (cyc > mul_t) && (cyc <= mul_t + MUL_LAT);
    return lu || (busy && ID_Valid && ID_ReadHiLo);
  endfunction

  function automatic int m_fwd(input int s, input bit st);
    if (st || !ID_Valid || s == 0) return 0;
    if (m_ex.w && m_ex.dst == s)   return 2;
    if (m_mem.w && m_mem.dst == s) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    bit st;
    st = m_stall();
    if (!RST_n) begin
      m_ex = '{0, 0, 0}; m_mem = '{0, 0, 0};
      exp_fa = 0; exp_fb = 0; exp_cnt = 0; mul_t = -100;
    end else begin
      exp_fa = m_fwd(int'(ID_Rs), st);
      exp_fb = m_fwd(int'(ID_Rt), st);
      if (ID_Valid && ID_MulStart && !st) mul_t = cyc;
      if (st && exp_cnt < CNT_MAX) exp_cnt++;
      m_mem = m_ex;
      if (st) m_ex = '{0, 0, 0};
      else    m_ex = '{ID_Valid && ID_RegWrite, int'(ID_WriteReg), ID_Valid && ID_MemToReg};
    end
    cyc++;
  end

  task automatic cmp(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit st;
      st = m_stall();
      cmp("StallF", int'(StallF), int'(st));
      cmp("StallD", int'(StallD), int'(st));
      cmp("FlushE", int'(FlushE), int'(st));
      cmp("FlushD", int'(FlushD), int'(ID_BranchTaken && ID_Valid && !st));
      cmp("ForwardAE", int'(ForwardAE), exp_fa);
      cmp("ForwardBE", int'(ForwardBE), exp_fb);
      cmp("StallCount", int'(StallCount), exp_cnt);
    end
  end

  task automatic issue(input bit v, input int rs, input int rt, input int wr, input bit rw,
                       input bit ld, input bit br = 0, input bit ms = 0, input bit rh = 0);
    @(posedge clk); #1;
    ID_Valid = v; ID_Rs = RAW'(rs); ID_Rt = RAW'(rt); ID_WriteReg = RAW'(wr);
    ID_RegWrite = rw; ID_MemToReg = ld; ID_BranchTaken = br; ID_MulStart = ms; ID_ReadHiLo = rh;
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int stalls;
    RST_n = 0;
    ID_Valid = 0; ID_Rs = '0; ID_Rt = '0; ID_WriteReg = '0; ID_RegWrite = 0;
    ID_MemToReg = 0; ID_BranchTaken = 0; ID_MulStart = 0; ID_ReadHiLo = 0;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    RST_n = 1;
    @(negedge clk);
    cmp("rst_cnt", int'(StallCount), 0);
    cmp("rst_fa", int'(ForwardAE), 0);
    cmp("rst_stall", int'(StallF), 0);

    // EX->EX forward
    issue(1, 1, 2, 3, 1, 0);
    issue(1, 3, 4, 6, 1, 0);
    @(negedge clk); cmp("t1_nostall", int'(StallF), 0);
    nop();
    @(negedge clk); cmp("t1_fa", int'(ForwardAE), 2);

    // Priority: younger producer of $5 wins; older one in MEM gives WB select
    issue(1, 0, 0, 5, 1, 0);
    issue(1, 0, 0, 5, 1, 0);
    issue(1, 7, 5, 0, 0, 0);
    nop();
    @(negedge clk); cmp("t2_fb_young", int'(ForwardBE), 2);
    issue(1, 0, 0, 5, 1, 0);
    issue(1, 0, 0, 9, 1, 0);
    issue(1, 7, 5, 0, 0, 0);
    nop();
    @(negedge clk); cmp("t2_fb_mem", int'(ForwardBE), 1);

    // Load-use: one stall, then forward from WB
    issue(1, 0, 0, 4, 1, 1);
    issue(1, 4, 0, 6, 1, 0);
    @(negedge clk); cmp("t3_stallF", int'(StallF), 1); cmp("t3_flushE", int'(FlushE), 1);
    issue(1, 4, 0, 6, 1, 0);
    @(negedge clk); cmp("t3_release", int'(StallF), 0);
    nop();
    @(negedge clk); cmp("t3_fa", int'(ForwardAE), 1); cmp("t3_cnt", int'(StallCount), 1);

    // Branch depending on a load: stall wins, flush next cycle
    issue(1, 0, 0, 8, 1, 1);
    issue(1, 8, 0, 0, 0, 0, 1);
    @(negedge clk); cmp("t5_flushD0", int'(FlushD), 0); cmp("t5_stall", int'(StallF), 1);
    issue(1, 8, 0, 0, 0, 0, 1);
    @(negedge clk); cmp("t5_flushD1", int'(FlushD), 1); cmp("t5_cnt", int'(StallCount), 2);

    // $0 is never forwarded
    issue(1, 0, 0, 0, 1, 0);
    issue(1, 0, 0, 0, 0, 0);
    nop();
    @(negedge clk); cmp("t4_zero_a", int'(ForwardAE), 0); cmp("t4_zero_b", int'(ForwardBE), 0);

    // Reset in the middle of a load-use stall
    issue(1, 0, 0, 4, 1, 1);
    issue(1, 4, 0, 6, 1, 0);
    @(negedge clk); cmp("t4_pre_stall", int'(StallF), 1);
    RST_n = 0;
    @(posedge clk); #1; RST_n = 1;
    @(negedge clk);
    cmp("t4_rst_stall", int'(StallF), 0);
    cmp("t4_rst_cnt", int'(StallCount), 0);
    cmp("t4_rst_fa", int'(ForwardAE), 0);

    // Multiply followed by mfhi
    issue(1, 0, 0, 0, 0, 0, 0, 1, 0);
    stalls = 0;
    for (int i = 0; i < 12; i++) begin
      issue(1, 0, 0, 2, 1, 0, 0, 0, 1);
      @(negedge clk);
      if (StallF) stalls++;
      else break;
    end
    cmp("t6_stalls", stalls, MULDIV ? 4 : 0);
    cmp("t6_cnt", int'(StallCount), MULDIV ? 4 : 0);

    // Counter saturation
    for (int i = 0; i < 20; i++) begin
      issue(1, 0, 0, 1, 1, 1);
      issue(1, 1, 0, 2, 1, 0);
      issue(1, 1, 0, 2, 1, 0);
    end
    nop();
    @(negedge clk); cmp("sat_cnt", int'(StallCount), CNT_MAX);

    // Random traffic on a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      RST_n          = ($urandom_range(0, 199) != 0);
      ID_Valid       = ($urandom_range(0, 9) != 0);
      ID_Rs          = RAW'($urandom_range(0, 7));
      ID_Rt          = RAW'($urandom_range(0, 7));
      ID_WriteReg    = RAW'($urandom_range(0, 7));
      ID_RegWrite    = ($urandom_range(0, 3) != 0);
      ID_MemToReg    = ($urandom_range(0, 2) == 0);
      ID_BranchTaken = ($urandom_range(0, 4) == 0);
      ID_MulStart    = ($urandom_range(0, 7) == 0);
      ID_ReadHiLo    = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk); #1; RST_n = 1;
    @(negedge clk);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
